// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice.
//   tx_state_e  : serialiser FSM states (IDLE, START, DATA, PARITY, STOP)
//   PAR_*       : parity-mode encodings used by the PARITY parameter
//   parity_bit  : parity of a data word for a given parity mode
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Callers pass the data zero-extended to 8 bits; the padding zeros do
    // not change the XOR, so any width from 5 to 8 works.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic even_par;
        even_par = ^data;
        if (mode == PAR_ODD) begin
            return ~even_par;
        end else if (mode == PAR_EVEN) begin
            return even_par;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy count.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : push request and data (ignored while full)
//   rd_en, rd_data    : pop request (ignored while empty), head-of-queue data
//   full, empty       : status derived from the registered count
//   count             : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Full and empty come from the registered count, so a push in the same
    // cycle as a pop from a full FIFO is still refused.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a small write FIFO in front of the serialiser.
// Ports:
//   sys_clk_i   : system clock, rising edge
//   rst         : asynchronous active-low reset
//   uart_wr_i   : write strobe, one word per high cycle
//   uart_dat_i  : write data (DATA_W bits)
//   baud_div_i  : bit period minus one, in clocks (latched per frame)
//   uart_tx     : registered serial line, idle high
//   uart_busy   : FIFO non-empty or a frame still on the line
//   uart_full   : FIFO full
//   fifo_count  : FIFO occupancy
//   uart_ovf    : sticky flag, set by a write while full, cleared by reset
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              sys_clk_i,
    input  logic              rst,
    input  logic              uart_wr_i,
    input  logic [DATA_W-1:0] uart_dat_i,
    input  logic [15:0]       baud_div_i,
    output logic              uart_tx,
    output logic              uart_busy,
    output logic              uart_full,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              uart_ovf
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       div_q, div_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              tx_q, tx_d;
    logic              active_q, active_d;
    logic              ovf_q, ovf_d;

    logic              bit_end;
    logic              load;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_rd_data;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk_i),
        .rst_n   (rst),
        .wr_en   (uart_wr_i),
        .wr_data (uart_dat_i),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The last clock of every bit period is the one where the counter has
    // reached the divider latched at frame start.
    assign bit_end = (cnt_q == div_q);

    // Next-state logic for the serialiser. A new frame is loaded either from
    // IDLE or straight out of the final stop bit, so consecutive frames run
    // without an idle gap. Loading pops the FIFO head and captures the word,
    // its parity and the divider, which keeps a later divider change out of
    // the frame already in flight.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_idx_d = bit_idx_q;
        load      = 1'b0;

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d   = ST_START;
            cnt_d     = '0;
            div_d     = baud_div_i;
            shreg_d   = fifo_rd_data;
            par_d     = parity_bit(8'(fifo_rd_data), PARITY);
            bit_idx_d = '0;
        end
    end

    assign pop = load;

    // The line is registered from the current state, so it trails the FSM
    // by one clock; this gives the two-edge write-to-start-bit latency.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    // active_q covers the extra clock the last stop bit spends on the line
    // after the FSM has already returned to IDLE.
    always_comb begin
        active_d = (state_q != ST_IDLE);
        ovf_d    = ovf_q | (uart_wr_i & fifo_full);
    end

    always_ff @(posedge sys_clk_i or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            active_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            active_q  <= active_d;
            ovf_q     <= ovf_d;
        end
    end

    assign uart_tx   = tx_q;
    assign uart_full = fifo_full;
    assign uart_ovf  = ovf_q;
    assign uart_busy = !fifo_empty || (state_q != ST_IDLE) || active_q;

endmodule
